// File: rtl/inst_fetch_unit_pkg.sv
// ============================================================================
// Module      : inst_fetch_unit_pkg
// Description : Shared encodings for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_fetch_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IFU_IDLE  = 3'd0,
        IFU_REQ   = 3'd1,
        IFU_WAIT  = 3'd2,
        IFU_HOLD  = 3'd3,
        IFU_DRAIN = 3'd4
    } ifu_state_e;

    localparam logic [1:0] FCAUSE_MISALIGN = 2'd0;
    localparam logic [1:0] FCAUSE_BUSERR   = 2'd1;
    localparam logic [1:0] FCAUSE_TIMEOUT  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/fetch_timeout_ctr.sv
// ============================================================================
// Module      : fetch_timeout_ctr
// Description : Wait-cycle counter; flags the last allowed cycle of a fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_timeout_ctr
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // A zero TIMEOUT_CYCLES disables expiry; the compare value is then unused.
    localparam bit              c_enabled = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] c_last   =
        c_enabled ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = c_enabled && enable && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// Module      : inst_fetch_unit
// Description : Single-beat instruction fetch with decode handshake and faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ack,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_busy,
    output logic            fault_valid,
    output logic [1:0]      fault_cause
);

    ifu_state_e      r_state;
    logic [XLEN-3:0] r_word_addr;
    logic            w_ctr_clear;
    logic            w_ctr_enable;
    logic            w_expired;

    // Only the word index is stored, so the bus address is aligned by construction.
    assign mem_addr     = {r_word_addr, 2'b00};
    assign fetch_busy   = (r_state != IFU_IDLE);
    assign w_ctr_clear  = (r_state == IFU_REQ) && mem_req_ready;
    assign w_ctr_enable = (r_state == IFU_WAIT);

    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout_ctr (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_ctr_clear),
        .enable  (w_ctr_enable),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IFU_IDLE;
            r_word_addr   <= '0;
            mem_req_valid <= 1'b0;
            inst_valid    <= 1'b0;
            inst_out      <= '0;
            inst_pc       <= '0;
            fault_valid   <= 1'b0;
            fault_cause   <= FCAUSE_MISALIGN;
        end else begin
            fault_valid <= 1'b0;
            case (r_state)
                IFU_IDLE: begin
                    if (fetch_req) begin
                        if (pc_in[1:0] != 2'b00) begin
                            fault_valid <= 1'b1;
                            fault_cause <= FCAUSE_MISALIGN;
                            inst_pc     <= pc_in;
                        end else begin
                            r_word_addr   <= pc_in[XLEN-1:2];
                            mem_req_valid <= 1'b1;
                            r_state       <= IFU_REQ;
                        end
                    end
                end
                IFU_REQ: begin
                    // An accepted request must have its response drained even when flushed.
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= flush ? IFU_DRAIN : IFU_WAIT;
                    end else if (flush) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= IFU_IDLE;
                    end
                end
                IFU_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_state <= IFU_IDLE;
                        if (!flush) begin
                            if (mem_rsp_err) begin
                                fault_valid <= 1'b1;
                                fault_cause <= FCAUSE_BUSERR;
                            end else begin
                                inst_out   <= mem_rsp_data;
                                inst_pc    <= mem_addr;
                                inst_valid <= 1'b1;
                                r_state    <= IFU_HOLD;
                            end
                        end
                    end else if (flush) begin
                        // A flush abandons the fetch, so it also suppresses a coincident timeout.
                        r_state <= IFU_DRAIN;
                    end else if (w_expired) begin
                        fault_valid <= 1'b1;
                        fault_cause <= FCAUSE_TIMEOUT;
                        r_state     <= IFU_DRAIN;
                    end
                end
                IFU_HOLD: begin
                    if (flush || inst_ack) begin
                        inst_valid <= 1'b0;
                        r_state    <= IFU_IDLE;
                    end
                end
                IFU_DRAIN: begin
                    if (mem_rsp_valid) begin
                        r_state <= IFU_IDLE;
                    end
                end
                default: begin
                    r_state <= IFU_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// ============================================================================
// Module      : tb_inst_fetch_unit
// Description : Directed and randomized checks of inst_fetch_unit against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] pc_in;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic        inst_ack;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_busy;
    logic        fault_valid;
    logic [1:0]  fault_cause;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_req     (fetch_req),
        .pc_in         (pc_in),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .inst_valid    (inst_valid),
        .inst_ack      (inst_ack),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .fetch_busy    (fetch_busy),
        .fault_valid   (fault_valid),
        .fault_cause   (fault_cause)
    );

    int n_vec = 0;
    int n_err = 0;

    // Expected visible outputs
    logic        e_req_valid;
    logic [31:0] e_addr;
    logic        e_inst_valid;
    logic [31:0] e_inst_out;
    logic [31:0] e_inst_pc;
    logic        e_fault_valid;
    logic [1:0]  e_fault_cause;
    // Outstanding fetch record
    bit          t_active;
    bit          t_accepted;
    bit          t_abandoned;
    int          t_waited;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_req_valid   = 1'b0;
        e_addr        = '0;
        e_inst_valid  = 1'b0;
        e_inst_out    = '0;
        e_inst_pc     = '0;
        e_fault_valid = 1'b0;
        e_fault_cause = 2'd0;
        t_active      = 1'b0;
        t_accepted    = 1'b0;
        t_abandoned   = 1'b0;
        t_waited      = 0;
    endtask

    task automatic model_step();
        e_fault_valid = 1'b0;
        if (e_inst_valid) begin
            if (flush || inst_ack) e_inst_valid = 1'b0;
        end else if (!t_active) begin
            if (fetch_req) begin
                if (pc_in[1:0] != 2'b00) begin
                    e_fault_valid = 1'b1;
                    e_fault_cause = 2'd0;
                    e_inst_pc     = pc_in;
                end else begin
                    t_active    = 1'b1;
                    t_accepted  = 1'b0;
                    t_abandoned = 1'b0;
                    e_addr      = pc_in;
                    e_req_valid = 1'b1;
                end
            end
        end else if (!t_accepted) begin
            if (mem_req_ready) begin
                t_accepted  = 1'b1;
                t_abandoned = flush;
                t_waited    = 0;
                e_req_valid = 1'b0;
            end else if (flush) begin
                t_active    = 1'b0;
                e_req_valid = 1'b0;
            end
        end else if (t_abandoned) begin
            if (mem_rsp_valid) t_active = 1'b0;
        end else if (mem_rsp_valid) begin
            t_active = 1'b0;
            if (!flush) begin
                if (mem_rsp_err) begin
                    e_fault_valid = 1'b1;
                    e_fault_cause = 2'd1;
                end else begin
                    e_inst_valid = 1'b1;
                    e_inst_out   = mem_rsp_data;
                    e_inst_pc    = e_addr;
                end
            end
        end else if (flush) begin
            t_abandoned = 1'b1;
        end else begin
            t_waited++;
            if (TO != 0 && t_waited == int'(TO)) begin
                e_fault_valid = 1'b1;
                e_fault_cause = 2'd2;
                t_abandoned   = 1'b1;
            end
        end
    endtask

    task automatic clr_in();
        fetch_req     = 1'b0;
        pc_in         = '0;
        flush         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        inst_ack      = 1'b0;
    endtask

    task automatic step();
        if (reset) model_reset();
        else       model_step();
        @(posedge clk);
        #1;
        chk("req_valid",   32'(mem_req_valid), 32'(e_req_valid));
        chk("mem_addr",    mem_addr,           e_addr);
        chk("inst_valid",  32'(inst_valid),    32'(e_inst_valid));
        chk("inst_out",    inst_out,           e_inst_out);
        chk("inst_pc",     inst_pc,            e_inst_pc);
        chk("fault_valid", 32'(fault_valid),   32'(e_fault_valid));
        chk("fault_cause", 32'(fault_cause),   32'(e_fault_cause));
        chk("busy",        32'(fetch_busy),    32'(t_active || e_inst_valid));
        clr_in();
    endtask

    // fetch_req -> REQ, accepted immediately, response after 'gap' idle WAIT cycles
    task automatic fetch_ok(input logic [31:0] pc, input logic [31:0] data, input int gap);
        fetch_req = 1'b1; pc_in = pc; step();
        mem_req_ready = 1'b1; step();
        for (int i = 0; i < gap; i++) step();
        mem_rsp_valid = 1'b1; mem_rsp_data = data; step();
    endtask

    initial begin
        clr_in();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();

        // Basic fetch
        fetch_ok(32'h4, 32'h0050_0093, 1);
        for (int i = 0; i < 3; i++) step();
        chk("basic_inst", inst_out, 32'h0050_0093);
        chk("basic_pc",   inst_pc,  32'h4);
        chk("basic_hold", 32'(inst_valid), 32'd1);
        inst_ack = 1'b1; step();
        chk("basic_ack", 32'(inst_valid), 32'd0);

        // Backpressure with an ignored second fetch_req
        fetch_req = 1'b1; pc_in = 32'h100; step();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin fetch_req = 1'b1; pc_in = 32'h200; end
            step();
            chk("bp_addr", mem_addr, 32'h100);
        end
        mem_req_ready = 1'b1; step();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_0001; step();
        chk("bp_pc", inst_pc, 32'h100);
        inst_ack = 1'b1; step();

        // Misaligned
        fetch_req = 1'b1; pc_in = 32'h6; step();
        chk("mis_fault", 32'(fault_valid), 32'd1);
        chk("mis_cause", 32'(fault_cause), 32'd0);
        chk("mis_pc",    inst_pc,          32'h6);
        chk("mis_noreq", 32'(mem_req_valid), 32'd0);
        step();

        // Bus error
        fetch_req = 1'b1; pc_in = 32'h10; step();
        mem_req_ready = 1'b1; step();
        mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1; mem_rsp_data = 32'hDEAD_BEEF; step();
        chk("berr_cause", 32'(fault_cause), 32'd1);
        chk("berr_noinst", 32'(inst_valid), 32'd0);
        step();

        // Flush in WAIT, late response drained, then a clean fetch
        fetch_req = 1'b1; pc_in = 32'h20; step();
        mem_req_ready = 1'b1; step();
        flush = 1'b1; step();
        step();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678; step();
        chk("drain_noinst", 32'(inst_valid), 32'd0);
        chk("drain_idle",   32'(fetch_busy), 32'd0);
        fetch_ok(32'h8, 32'h0000_0013, 0);
        chk("post_flush_pc", inst_pc, 32'h8);
        inst_ack = 1'b1; step();

        // Timeout after TO wait cycles, then drain the late response
        fetch_req = 1'b1; pc_in = 32'h30; step();
        mem_req_ready = 1'b1; step();
        for (int i = 0; i < int'(TO); i++) step();
        chk("to_fault", 32'(fault_valid), 32'd1);
        chk("to_cause", 32'(fault_cause), 32'd2);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_AAAA; step();
        chk("to_drained", 32'(inst_valid), 32'd0);

        // Reset mid-WAIT
        fetch_req = 1'b1; pc_in = 32'h40; step();
        mem_req_ready = 1'b1; step();
        step();
        reset = 1'b1; step();
        chk("rst_cause", 32'(fault_cause), 32'd0);
        chk("rst_inst",  inst_out,         32'd0);
        reset = 1'b0; step();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            reset         = ($urandom_range(0, 499) == 0);
            fetch_req     = ($urandom_range(0, 9) < 4);
            pc_in         = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) pc_in[1:0] = 2'($urandom_range(1, 3));
            flush         = ($urandom_range(0, 19) == 0);
            mem_req_ready = ($urandom_range(0, 1) == 1);
            mem_rsp_valid = t_active && t_accepted && ($urandom_range(0, 9) < 3);
            mem_rsp_err   = mem_rsp_valid && ($urandom_range(0, 4) == 0);
            mem_rsp_data  = $urandom();
            inst_ack      = ($urandom_range(0, 9) < 4);
            step();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
